// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16 x 16-bit register file.
// Contents: DATA_W / NREG / ADDR_W sizing, REG_ZERO index of the hardwired
// zero register, a write-request struct and a one-hot write decoder.
package regfile_pkg;
  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    word_t             data;
  } wr_req_t;

  // 4->16 one-hot decode; all-zero when the request is not enabled.
  function automatic logic [NREG-1:0] wr_decode(input wr_req_t req);
    logic [NREG-1:0] oh;
    oh = '0;
    if (req.we) oh[req.addr] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/reg16_en.sv
// 16-bit register with synchronous active-high reset and load enable.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous reset, clears q (wins over en)
//   en   in   load enable
//   d    in   DATA_W data in
//   q    out  DATA_W registered data
module reg16_en
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  word_t d,
  output word_t q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/regfile_rmux.sv
// 16:1 16-bit read-select mux used by every read port of the register file.
// Ports:
//   din   in   NREG x DATA_W packed candidate words
//   sel   in   ADDR_W select index
//   dout  out  DATA_W selected word
module regfile_rmux
  import regfile_pkg::*;
(
  input  logic [NREG-1:0][DATA_W-1:0] din,
  input  logic [ADDR_W-1:0]           sel,
  output word_t                       dout
);
  assign dout = din[sel];
endmodule

// File: rtl/regfile16_16bit.sv
// 16 x 16-bit register file: one synchronous write port, two combinational
// operand read ports (A, B), one combinational debug read port and a
// committed-write counter. R0 reads as zero and ignores writes.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a committed write to the index read on A/B is forwarded to
//               that port in the same cycle (DBG is never forwarded)
//   undefined - A/B show the pre-write value during the write cycle
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset (clears regs and WR_CNT)
//   WE        in   write enable
//   WADDR     in   write index
//   WDATA     in   write data
//   RADDR_A   in   read index, port A
//   RADDR_B   in   read index, port B
//   RDATA_A   out  read data, port A
//   RDATA_B   out  read data, port B
//   DBG_SEL   in   debug read index
//   DBG_DATA  out  debug read data
//   WR_CNT    out  committed writes since reset (wraps)
module regfile16_16bit
  import regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [ADDR_W-1:0] RADDR_A,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [DATA_W-1:0] RDATA_A,
  output logic [DATA_W-1:0] RDATA_B,
  input  logic [ADDR_W-1:0] DBG_SEL,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic [DATA_W-1:0] WR_CNT
);
  wr_req_t                     wr;
  logic                        commit;
  logic [NREG-1:0]             wr_en;
  logic [NREG-1:0][DATA_W-1:0] regs;
  word_t                       rd_a, rd_b;

  // A commit is a write that actually changes state; reset drops it.
  assign commit = WE && !RST && (WADDR != REG_ZERO);
  assign wr     = '{we: commit, addr: WADDR, data: WDATA};
  assign wr_en  = wr_decode(wr);

  assign regs[0] = '0;

  genvar i;
  generate
    for (i = 1; i < NREG; i++) begin : g_reg
      reg16_en u_reg (
        .clk (CLK),
        .rst (RST),
        .en  (wr_en[i]),
        .d   (WDATA),
        .q   (regs[i])
      );
    end
  endgenerate

  regfile_rmux u_mux_a (.din(regs), .sel(RADDR_A), .dout(rd_a));
  regfile_rmux u_mux_b (.din(regs), .sel(RADDR_B), .dout(rd_b));
  regfile_rmux u_mux_d (.din(regs), .sel(DBG_SEL), .dout(DBG_DATA));

`ifdef REGFILE_BYPASS_EN
  // commit already excludes RST and R0, so forwarding inherits both rules.
  assign RDATA_A = (commit && (RADDR_A == WADDR)) ? WDATA : rd_a;
  assign RDATA_B = (commit && (RADDR_B == WADDR)) ? WDATA : rd_b;
`else
  assign RDATA_A = rd_a;
  assign RDATA_B = rd_b;
`endif

  always_ff @(posedge CLK) begin
    if (RST)         WR_CNT <= '0;
    else if (commit) WR_CNT <= WR_CNT + 16'd1;
  end
endmodule
